// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-high, bit0 = a .. bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Patterns for digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Digit positions, 0 = rightmost.
  localparam logic [2:0] IDX_SEC1  = 3'd0;
  localparam logic [2:0] IDX_SEC2  = 3'd1;
  localparam logic [2:0] IDX_MIN1  = 3'd2;
  localparam logic [2:0] IDX_MIN2  = 3'd3;
  localparam logic [2:0] IDX_HOUR1 = 3'd4;
  localparam logic [2:0] IDX_HOUR2 = 3'd5;

  // Decimal points form the hh.mm.ss separators.
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to seven-segment decoder (combinational).
// Ports:
//   bcd_i  4-bit digit value
//   seg_o  7-bit active-high pattern (bit0 = a); blank for values above 9
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit seven-segment display driver.
// A per-frame snapshot of the BCD digits is scanned out one digit per slot,
// with all anodes off for the first BLANK_CYCLES of each slot.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sec1..hour2         BCD digits, index 0 (sec1) .. 5 (hour2)
//   set, select         set mode and digit under edit (6/7 = none); edited digit blinks
//   lz_blank            suppress a zero hour2
//   seg, dp, an         registered display pins (polarity set by ACTIVE_LOW)
//   frame_done          one-cycle pulse marking a new frame / snapshot capture
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 83,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hour1,
  input  logic [3:0] hour2,
  input  logic       set,
  input  logic [2:0] select,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [5:0][3:0]   snap_q, snap_d;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [5:0] an_q, an_d;
  logic       frame_done_q, frame_done_d;

  logic       slot_end, frame_end;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic       blank;

  // Counters and snapshot
  always_comb begin
    slot_end  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IDX_HOUR2);

    div_cnt_d = slot_end ? '0 : div_cnt_q + DIV_W'(1);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_HOUR2) ? '0 : idx_q + 3'd1;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    snap_d = frame_end ? {hour2, hour1, min2, min1, sec2, sec1} : snap_q;
  end

  // Digit selection and blanking
  always_comb begin
    cur_digit = '0;
    case (idx_q)
      IDX_SEC1:  cur_digit = snap_q[0];
      IDX_SEC2:  cur_digit = snap_q[1];
      IDX_MIN1:  cur_digit = snap_q[2];
      IDX_MIN2:  cur_digit = snap_q[3];
      IDX_HOUR1: cur_digit = snap_q[4];
      IDX_HOUR2: cur_digit = snap_q[5];
      default:   cur_digit = '0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    blank = (cur_digit > 4'd9)
         || (lz_blank && (idx_q == IDX_HOUR2) && (snap_q[5] == 4'd0))
         || (set && (select == idx_q) && blink_phase_q);

    // Pin-level values: XOR with ACTIVE_LOW gives the inversion when needed.
    seg_d = (blank ? SEG_BLANK : dec_seg) ^ {7{ACTIVE_LOW}};
    dp_d  = (DP_MASK[idx_q] && !blank) ^ ACTIVE_LOW;
    an_d  = ((div_cnt_q >= DIV_W'(BLANK_CYCLES)) ? (6'd1 << idx_q) : 6'd0)
          ^ {6{ACTIVE_LOW}};
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      seg_q         <= {7{ACTIVE_LOW}};
      dp_q          <= ACTIVE_LOW;
      an_q          <= {6{ACTIVE_LOW}};
      frame_done_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2, ACTIVE_LOW=1). Expected pin values per clock are derived
// from the cycle count since reset and the frame snapshot rules.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int          FRAME        = SCAN_DIV * 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din [6];
  logic       set;
  logic [2:0] select;
  logic       lz_blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  bit clk_en = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  seg7_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec1       (din[0]),
    .sec2       (din[1]),
    .min1       (din[2]),
    .min2       (din[3]),
    .hour1      (din[4]),
    .hour2      (din[5]),
    .set        (set),
    .select     (select),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    int         k;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    bit         active;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   snap [6];

  task automatic check(string name, int k, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s at k=%0d got %0h expected %0h", name, k, got, expv);
    end
  endtask

  function automatic logic [6:0] seg_ref(int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected pins in the cycle after clock edge k (k=1 is the first edge
  // after reset release); they show the scan position reached after k-1 edges.
  function automatic exp_t model(int k);
    exp_t e;
    int s, pos, idx, frame;
    bit blank;
    logic [6:0] sg;
    s     = k - 1;
    pos   = s % SCAN_DIV;
    idx   = (s / SCAN_DIV) % 6;
    frame = s / FRAME;
    blank = (snap[idx] > 9)
         || (lz_blank && idx == 5 && snap[5] == 0)
         || (set && int'(select) == idx && ((frame / BLINK_FRAMES) % 2 == 1));
    sg       = blank ? 7'h00 : seg_ref(snap[idx]);
    e.k      = k;
    e.active = (pos >= BLANK_CYCLES);
    e.an     = e.active ? ~(6'd1 << idx) : 6'h3F;
    e.seg    = ~sg;
    e.dp     = ~((idx == 2 || idx == 4) && !blank);
    e.fd     = (k % FRAME == 0);
    return e;
  endfunction

  task automatic set_time(int h2, int h1, int m2, int m1, int s2, int s1);
    din[5] = 4'(h2); din[4] = 4'(h1); din[3] = 4'(m2);
    din[2] = 4'(m1); din[1] = 4'(s2); din[0] = 4'(s1);
  endtask

  task automatic apply_table(int f);
    set = 1'b0; select = 3'd7; lz_blank = 1'b0;
    set_time(1, 2, 3, 4, 5, 6);
    case (f)
      2:       set_time(9, 9, 9, 9, 9, 9);
      3:       din[0] = 4'hF;
      4, 5, 6, 7, 8, 9: begin set = 1'b1; select = 3'd3; end
      10:      begin set = 1'b1; select = 3'd6; end
      11:      begin set = 1'b0; select = 3'd3; end
      12:      begin lz_blank = 1'b1; din[5] = 4'd0; end
      13:      lz_blank = 1'b1;
      default: ;
    endcase
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 6; i++) begin
      din[i] = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 10))
                                        : 4'($urandom_range(9));
    end
    if ($urandom_range(3) == 0) din[5] = 4'd0;
    set      = 1'($urandom_range(1));
    select   = 3'($urandom_range(7));
    lz_blank = 1'($urandom_range(1));
  endtask

  // Scripted frames first, then random input changes at random cycles.
  task automatic run(int frames, bit scripted);
    exp_t e;
    for (int k = 1; k <= frames * FRAME; k++) begin
      #1;
      if (scripted && (k / FRAME) < 14) begin
        // Changes land mid-frame (during idx3), exercising anti-tear.
        if (k % FRAME == 28) apply_table(k / FRAME);
      end else if ($urandom_range(19) == 0) begin
        randomize_inputs();
      end
      e = model(k);
      if (k % FRAME == 0) begin
        for (int i = 0; i < 6; i++) snap[i] = int'(din[i]);
      end
      @(posedge clk);
      q.push_back(e);
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an", e.k, int'(an), int'(e.an));
        check("frame_done", e.k, int'(frame_done), int'(e.fd));
        if (e.active) begin
          check("seg", e.k, int'(seg), int'(e.seg));
          check("dp", e.k, int'(dp), int'(e.dp));
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; set = 1'b0; select = 3'd7; lz_blank = 1'b0;
    for (int i = 0; i < 6; i++) din[i] = 4'd0;
    #1 rst = 1'b1;
    #1;
    check("reset_seg", 0, int'(seg), 'h7F);
    check("reset_dp", 0, int'(dp), 1);
    check("reset_an", 0, int'(an), 'h3F);
    check("reset_fd", 0, int'(frame_done), 0);

    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) snap[i] = 0;
    run(30, 1'b1);

    // Reset mid-slot: pins go inactive before any clock edge.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_an", -1, int'(an), 'h3F);
    check("midreset_seg", -1, int'(seg), 'h7F);
    check("midreset_dp", -1, int'(dp), 1);
    check("midreset_fd", -1, int'(frame_done), 0);
    @(posedge clk);
    #1 check("midreset_hold_an", -1, int'(an), 'h3F);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) snap[i] = 0;
    run(4, 1'b0);

    @(negedge clk);
    #1 check("scoreboard_drained", -1, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed 6-digit seven-segment display driver that consumes the BCD digit outputs of the clock counter (sec1, sec2, min1, min2, hour1, hour2) and drives shared segment lines plus per-digit anode enables. Latches a per-frame snapshot of the digits to prevent tearing and inserts anode dead-time between digits to prevent ghosting. Blinks the digit being edited in set mode and optionally suppresses a leading hour zero. Sits between the clock core and the board display pins.

Parameters:
SCAN_DIV, 100000, clocks per digit slot; legal iff SCAN_DIV >= BLANK_CYCLES+2.
BLANK_CYCLES, 4, clocks at the start of each slot with all anodes off (dead-time).
BLINK_FRAMES, 83, full frames per blink half-period.
ACTIVE_LOW, 1, 1 = seg, dp and an pins are active-low; 0 = active-high.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sec1  input  4  seconds units BCD (digit index 0, rightmost)
sec2  input  4  seconds tens BCD (index 1)
min1  input  4  minutes units BCD (index 2)
min2  input  4  minutes tens BCD (index 3)
hour1  input  4  hours units BCD (index 4)
hour2  input  4  hours tens BCD (index 5, leftmost)
set  input  1  clock is in set mode
select  input  3  digit being edited, 0..5; 6,7 = none
lz_blank  input  1  suppress hour2 when it equals 0
seg  output  7  segments, bit0=a .. bit6=g
dp  output  1  decimal point
an  output  6  anode enables, bit i = digit index i
frame_done  output  1  one-cycle pulse when a new frame starts and the snapshot is captured

Behaviour:
- Single clock domain. One clock: clk. Reset rst is asynchronous and active-high.
- Reset: div_cnt=0, idx=0, blink_cnt=0, blink_phase=0, snapshot=all zero; outputs driven inactive immediately without a clock: seg all off, dp off, an all off, frame_done=0. With ACTIVE_LOW=1 this is seg=7'h7F, dp=1, an=6'h3F.
- Slot timing: div_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances 0->1->...->5->0.
- Dead-time: while div_cnt < BLANK_CYCLES, all anodes are off. Otherwise, only the anode for idx is on. Exactly SCAN_DIV-BLANK_CYCLES active cycles per slot.
- Snapshot: captured from the inputs in the cycle idx wraps from 5 to 0. frame_done pulses high for that same cycle. Input changes mid-frame do not affect the display until the next capture. The first frame after reset displays the reset snapshot (all zeros).
- Decode, active-high g..a: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles 10..15 decode to blank (all segments off); set-mode adjustment upstream can produce these.
- dp is lit on idx 2 and idx 4 as the hh.mm.ss separators.
- Blink: blink_cnt counts frames 0..BLINK_FRAMES-1. On wrap, blink_phase toggles. If set=1, select==idx, and blink_phase=1, that digit's segments and dp are blanked. The anode timing is unchanged. select 6/7 never blanks.
- Leading zero: if lz_blank=1 and snapshot hour2==0, segments are blank on idx5.
- Priority of blanking: invalid nibble, leading zero, and blink are OR-ed together. Any one of them blanks the digit.
- Polarity: when ACTIVE_LOW=1, seg, dp and an are inverted at the pins.
- All pin outputs are registered. Each pin reflects the internal div_cnt/idx state with exactly 1 clock of latency. frame_done is also registered.
- Async reset asserted mid-slot forces outputs inactive immediately. After release, scanning restarts at idx0, div_cnt=0.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK constant;
  - the 10-entry active-high segment pattern table;
  - digit index constants IDX_SEC1..IDX_HOUR2;
  - DP_MASK (indices 2, 4).
- Sub-module bcd_to_seg7: combinational, 4-bit in, 7-bit active-high pattern out, blank for values above 9.
- The top module holds the counters, snapshot, blink logic, output registers and polarity.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, ACTIVE_LOW=1):
1. Reset and timing: assert rst with no clock -> seg=7F, dp=1, an=3F at once. Release -> each slot shows an=3F for 2 cycles, then the idx anode low for 6 cycles. Slot order is idx0..5. frame_done is exactly one cycle every 48 clocks.
2. Display 12:34:56 (hour2=1, hour1=2, min2=3, min1=4, sec2=5, sec1=6), read from the second frame onward -> seg per idx0..5 = 02, 12, 19, 30, 24, 79. dp=0 only on idx2 and idx4.
3. Anti-tear: change every input to 9 while idx=3 is active -> idx4 and idx5 still show 24 and 79 in that frame. All digits show 10 from the frame after the next frame_done.
4. Invalid nibble: sec1=4'hF -> seg=7F and dp=1 during slot 0, while the anode is still driven low.
5. Blink: set=1, select=3 -> idx3 segments are 7F in alternating 2-frame windows, and other digits are unaffected. select=6 -> no blanking. set=0 with select=3 -> no blanking.
6. Leading zero and mid-op reset: lz_blank=1, hour2=0 -> idx5 seg=7F. Set hour2=1 -> 79 after the next capture. Assert rst mid-slot -> an=3F before the next clk edge, and scanning resumes at idx0 after release.
